seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 50000: clk cycles per digit slot, legal range >= 2.
REQ-003 SHALL have parameter HEX_EN, default 0: 1 means nibbles 10..15 display A..F; 0 means decimal-only.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port load, input, 1: capture value/dp_mask/blank_lz into shadow this cycle.
REQ-007 SHALL have port value, input, 4*NUM_DIGITS: packed nibbles; digit i = value[4i+3:4i]; digit 0 is least significant.
REQ-008 SHALL have port dp_mask, input, NUM_DIGITS: decimal point request per digit.
REQ-009 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-010 SHALL have port seg, output, 8: segment pattern, bit order hgfedcba, active-high, h = decimal point.
REQ-011 SHALL have port an, output, NUM_DIGITS: one-hot active-high digit select.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse per completed scan frame.

Function
REQ-013 SHALL run prescaler count 0..PRESCALE-1, wrapping to 0; digit index advances on each prescaler wrap, 0..NUM_DIGITS-1, wrapping to 0.
REQ-014 SHALL register seg and an from the current index and active register; outputs lag index by exactly 1 cycle.
REQ-015 SHALL decode digits 0..9 as 00111111, 00000110, 01011011, 01001111, 01100110, 01101101, 01111101, 00000111, 01111111, 01101111.
REQ-016 With HEX_EN=1, SHALL decode 10..15 as 01110111, 01111100, 00111001, 01011110, 01111001, 01110001; with HEX_EN=0, SHALL decode 10..15 as error pattern 10000000.
REQ-017 SHALL force seg bit7 = error-pattern bit OR active dp_mask[index].
REQ-018 SHALL double-buffer: load writes shadow and sets pending; when index wraps NUM_DIGITS-1 -> 0 with pending set, active <= shadow and pending clears.
REQ-019 SHALL let multiple loads within one frame overwrite the shadow (last wins); a load in the wrap cycle updates shadow only and takes effect at the next wrap.
REQ-020 SHALL pulse frame_done high for the cycle in which index wraps NUM_DIGITS-1 -> 0.
REQ-021 With active blank_lz=1, SHALL output seg=00000000 for digit i>0 when nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never blanked; a blanked digit's dp still shows if requested.
REQ-022 SHALL keep exactly one an bit high at all times outside reset and the first post-reset cycle.

Reset
REQ-023 On rst, SHALL clear prescaler, index, shadow, active, and pending, and drive seg=0, an=0, frame_done=0 on the following cycle.
REQ-024 After rst deasserts, SHALL show an=0...01 from the second cycle; rst mid-frame SHALL abort the frame and restart at digit 0, discarding pending data.

Structure
REQ-025 SHALL place segment constants (digit/hex patterns, SEG_BLANK=00000000, SEG_ERR=10000000) in shared package seg7_pkg.
REQ-026 SHALL implement nibble decode as combinational sub-module seg7_digit_lut (input nibble, hex_en; output 8-bit pattern); all state lives in seg7_scan_driver.

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-027 SHALL cover: reset then idle -> an sequence 0001, 0010, 0100, 1000, each held for 4 cycles, then 0001; frame_done pulses once per 16 cycles.
REQ-028 SHALL cover: load value=16'h1234, dp_mask=0100 mid-frame -> display unchanged until the wrap; then digit0..3 show 01100110, 01001111, 11011011, 00000110.
REQ-029 SHALL cover: blank_lz=1, value=16'h0050 -> digits 3 and 2 show 00000000, digit1 shows 01101101, digit0 shows 00111111; value=16'h0000 -> only digit0 shows 00111111.
REQ-030 SHALL cover: nibble 4'hA -> 10000000 with HEX_EN=0 and 01110111 with HEX_EN=1.
REQ-031 SHALL cover: two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is displayed; a load coincident with frame_done -> displayed one frame later.
REQ-032 SHALL cover: rst asserted at index 2 -> seg=0 and an=0 the next cycle; scan resumes at digit 0 with active=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and helpers for the multiplexed display driver.
// Segment bit order is hgfedcba, active-high, h = decimal point.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;
  localparam logic [7:0] SEG_ERR   = 8'b1000_0000;

  localparam logic [7:0] SEG_0 = 8'b0011_1111;
  localparam logic [7:0] SEG_1 = 8'b0000_0110;
  localparam logic [7:0] SEG_2 = 8'b0101_1011;
  localparam logic [7:0] SEG_3 = 8'b0100_1111;
  localparam logic [7:0] SEG_4 = 8'b0110_0110;
  localparam logic [7:0] SEG_5 = 8'b0110_1101;
  localparam logic [7:0] SEG_6 = 8'b0111_1101;
  localparam logic [7:0] SEG_7 = 8'b0000_0111;
  localparam logic [7:0] SEG_8 = 8'b0111_1111;
  localparam logic [7:0] SEG_9 = 8'b0110_1111;

  localparam logic [7:0] SEG_A = 8'b0111_0111;
  localparam logic [7:0] SEG_B = 8'b0111_1100;
  localparam logic [7:0] SEG_C = 8'b0011_1001;
  localparam logic [7:0] SEG_D = 8'b0101_1110;
  localparam logic [7:0] SEG_E = 8'b0111_1001;
  localparam logic [7:0] SEG_F = 8'b0111_0001;

  // Selected digit as seen by the output stage.
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] nibble;
  } digit_sel_t;

  // The decimal point shares bit 7 with the error marker, so it is OR-ed in.
  function automatic logic [7:0] seg_with_dp(input logic [7:0] pattern, input logic dp);
    return {pattern[7] | dp, pattern[6:0]};
  endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational nibble-to-segment decoder; nibbles 10..15 show A..F only when
// hex_en is set, otherwise they show the error pattern.
module seg7_digit_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [7:0] pattern
);

  always_comb begin
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_en ? SEG_A : SEG_ERR;
      4'hB: pattern = hex_en ? SEG_B : SEG_ERR;
      4'hC: pattern = hex_en ? SEG_C : SEG_ERR;
      4'hD: pattern = hex_en ? SEG_D : SEG_ERR;
      4'hE: pattern = hex_en ? SEG_E : SEG_ERR;
      4'hF: pattern = hex_en ? SEG_F : SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with a double-buffered display value,
// leading-zero blanking and per-digit decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int HEX_EN     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_PENULT = PW'(PRESCALE - 2);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_p0;
  logic [IW-1:0]           idx_p0;
  logic [4*NUM_DIGITS-1:0] shadow_val_p0, active_val_p0;
  logic [NUM_DIGITS-1:0]   shadow_dp_p0, active_dp_p0;
  logic                    shadow_blz_p0, active_blz_p0, pending_p0;

  logic [7:0]            seg_p1;
  logic [NUM_DIGITS-1:0] an_p1;
  logic                  frame_done_p1;

  logic       presc_wrap, frame_wrap, frame_soon, upper_zero;
  digit_sel_t cur;
  logic [7:0] lut_pat, seg_next;

  assign presc_wrap = (presc_p0 == PRESC_LAST);
  assign frame_wrap = presc_wrap && (idx_p0 == IDX_LAST);
  // frame_done is registered one cycle early so it is high during the wrap cycle.
  assign frame_soon = (presc_p0 == PRESC_PENULT) && (idx_p0 == IDX_LAST);

  // Stage p0 -> p1: select the scanned digit from the active buffer and decode it.
  always_comb begin
    cur        = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (active_val_p0[4*i +: 4] == 4'd0);
      if (idx_p0 == IW'(i)) begin
        cur.nibble = active_val_p0[4*i +: 4];
        cur.dp     = active_dp_p0[i];
        cur.blank  = active_blz_p0 && (i != 0) && upper_zero;
      end
    end
  end

  seg7_digit_lut u_lut (
    .nibble  (cur.nibble),
    .hex_en  (HEX_EN != 0),
    .pattern (lut_pat)
  );

  assign seg_next = seg_with_dp(cur.blank ? SEG_BLANK : lut_pat, cur.dp);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0      <= '0;
      idx_p0        <= '0;
      shadow_val_p0 <= '0;
      shadow_dp_p0  <= '0;
      shadow_blz_p0 <= 1'b0;
      active_val_p0 <= '0;
      active_dp_p0  <= '0;
      active_blz_p0 <= 1'b0;
      pending_p0    <= 1'b0;
      seg_p1        <= '0;
      an_p1         <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      presc_p0 <= presc_wrap ? '0 : presc_p0 + PW'(1);
      if (presc_wrap) begin
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
      end

      // A load on the wrap cycle still lands in the shadow and waits a frame.
      if (frame_wrap && pending_p0) begin
        active_val_p0 <= shadow_val_p0;
        active_dp_p0  <= shadow_dp_p0;
        active_blz_p0 <= shadow_blz_p0;
      end
      if (load) begin
        shadow_val_p0 <= value;
        shadow_dp_p0  <= dp_mask;
        shadow_blz_p0 <= blank_lz;
        pending_p0    <= 1'b1;
      end else if (frame_wrap) begin
        pending_p0 <= 1'b0;
      end

      seg_p1        <= seg_next;
      an_p1         <= NUM_DIGITS'(1) << idx_p0;
      frame_done_p1 <= frame_soon;
    end
  end

  assign seg        = seg_p1;
  assign an         = an_p1;
  assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, prescale 4), decimal and hex builds
// side by side against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int PRE = 4;
  localparam int FRAME = ND * PRE;

  localparam logic [7:0] DEC_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  localparam logic [7:0] HEX_TAB [6]  = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic clk = 1'b0;
  logic rst, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic        fd0, fd1;

  int total = 0;
  int bad   = 0;
  int fd_count = 0;

  // Reference model: tick count since reset plus the double-buffer contents.
  int          mk;
  logic [15:0] m_sh_v, m_ac_v;
  logic [3:0]  m_sh_dp, m_ac_dp;
  logic        m_sh_b, m_ac_b, m_pend;
  logic [7:0]  exp_seg0, exp_seg1;
  logic [3:0]  exp_an;
  logic        exp_fd;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PRE), .HEX_EN(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg0), .an(an0), .frame_done(fd0)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PRE), .HEX_EN(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg1), .an(an1), .frame_done(fd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp,
                                           input logic blz, input int idx, input bit hex);
    logic [15:0] upper;
    int          nib;
    logic [7:0]  p;
    logic        d;
    upper = v >> (4 * idx);
    nib   = int'(upper & 16'h000F);
    d     = dp[idx];
    if (blz && idx > 0 && upper == 16'h0000) return {d, 7'b0};
    if (nib < 10) p = DEC_TAB[nib];
    else if (hex) p = HEX_TAB[nib - 10];
    else p = 8'h80;
    return p | {d, 7'b0};
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] dp, input logic blz);
    int idx;
    bit wrap;
    rst = r; load = ld; value = v; dp_mask = dp; blank_lz = blz;
    @(posedge clk);
    if (r) begin
      mk = 0;
      m_sh_v = '0; m_sh_dp = '0; m_sh_b = 1'b0;
      m_ac_v = '0; m_ac_dp = '0; m_ac_b = 1'b0;
      m_pend = 1'b0;
      exp_seg0 = 8'h00; exp_seg1 = 8'h00; exp_an = 4'h0; exp_fd = 1'b0;
    end else begin
      idx      = (mk / PRE) % ND;
      exp_seg0 = model_seg(m_ac_v, m_ac_dp, m_ac_b, idx, 1'b0);
      exp_seg1 = model_seg(m_ac_v, m_ac_dp, m_ac_b, idx, 1'b1);
      exp_an   = 4'(1 << idx);
      exp_fd   = ((mk + 1) % FRAME) == FRAME - 1;
      wrap     = (mk % FRAME) == FRAME - 1;
      if (wrap && m_pend) begin
        m_ac_v = m_sh_v; m_ac_dp = m_sh_dp; m_ac_b = m_sh_b;
      end
      if (ld) begin
        m_sh_v = v; m_sh_dp = dp; m_sh_b = blz; m_pend = 1'b1;
      end else if (wrap) begin
        m_pend = 1'b0;
      end
      mk++;
    end
    #1;
    chk("seg_dec", seg0, exp_seg0);
    chk("seg_hex", seg1, exp_seg1);
    chk("an_dec", an0, exp_an);
    chk("an_hex", an1, exp_an);
    chk("fd_dec", fd0, exp_fd);
    chk("fd_hex", fd1, exp_fd);
    if (fd0 === 1'b1) fd_count++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
  endtask

  task automatic wait_fd();
    bit found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      if (fd0 === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("wait_frame_done", 32'(found), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] pat);
    bit found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      if (an0 === pat) begin
        found = 1;
        break;
      end
    end
    chk("wait_an", 32'(found), 32'd1);
  endtask

  task automatic expect_digit(input int d, input logic [7:0] p0, input logic [7:0] p1);
    wait_an(4'(1 << d));
    chk("digit_dec", seg0, p0);
    chk("digit_hex", seg1, p1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b0;

    // Reset, then idle scan: one frame_done per 16 cycles.
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    chk("reset_seg", seg0, 8'h00);
    chk("reset_an", an0, 4'h0);
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    fd_count = 0;
    idle();
    chk("first_an", an0, 4'b0001);
    for (int i = 0; i < 2 * FRAME - 1; i++) idle();
    chk("fd_per_32", fd_count, 2);

    // Mid-frame load with a decimal point on digit 2.
    for (int i = 0; i < 5; i++) idle();
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
    wait_fd();
    expect_digit(0, 8'b0110_0110, 8'b0110_0110);
    expect_digit(1, 8'b0100_1111, 8'b0100_1111);
    expect_digit(2, 8'b1101_1011, 8'b1101_1011);
    expect_digit(3, 8'b0000_0110, 8'b0000_0110);

    // Leading-zero blanking.
    step(1'b0, 1'b1, 16'h0050, 4'h0, 1'b1);
    wait_fd();
    expect_digit(0, 8'b0011_1111, 8'b0011_1111);
    expect_digit(1, 8'b0110_1101, 8'b0110_1101);
    expect_digit(2, 8'h00, 8'h00);
    expect_digit(3, 8'h00, 8'h00);
    step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
    wait_fd();
    expect_digit(0, 8'b0011_1111, 8'b0011_1111);
    expect_digit(1, 8'h00, 8'h00);
    expect_digit(2, 8'h00, 8'h00);
    expect_digit(3, 8'h00, 8'h00);

    // Nibble A: error marker in decimal build, letter A in hex build.
    step(1'b0, 1'b1, 16'h000A, 4'h0, 1'b0);
    wait_fd();
    expect_digit(0, 8'b1000_0000, 8'b0111_0111);

    // Two loads in one frame: the last one wins.
    wait_fd();
    idle();
    step(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle();
    step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
    wait_fd();
    for (int d = 0; d < ND; d++) expect_digit(d, 8'b0101_1011, 8'b0101_1011);

    // Load during the frame_done cycle shows one frame later.
    wait_fd();
    step(1'b0, 1'b1, 16'h8888, 4'h0, 1'b0);
    expect_digit(0, 8'b0101_1011, 8'b0101_1011);
    wait_fd();
    expect_digit(0, 8'b0111_1111, 8'b0111_1111);

    // Reset at digit 2 with a pending load: pending data is dropped.
    wait_fd();
    idle();
    step(1'b0, 1'b1, 16'h9999, 4'h0, 1'b0);
    wait_an(4'b0100);
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    chk("midrst_seg", seg0, 8'h00);
    chk("midrst_an", an0, 4'h0);
    chk("midrst_fd", fd0, 1'b0);
    idle();
    chk("resume_an", an0, 4'b0001);
    chk("resume_seg", seg0, 8'b0011_1111);
    wait_fd();
    expect_digit(0, 8'b0011_1111, 8'b0011_1111);
    expect_digit(3, 8'b0011_1111, 8'b0011_1111);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic        r, ld, blz;
      logic [15:0] v;
      logic [3:0]  dp;
      r   = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      v   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp  = 4'($urandom);
      blz = 1'($urandom);
      step(r, ld, v, dp, blz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
